// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the CPU instruction memory: frames of count, little-endian
// payload words and an XOR checksum. The CPU is held in reset until a good load finishes.
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_WIDTH:0] ONE_W = 1;

  state_t                state;
  state_t                state_nx;
  logic                  ready_en;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [ADDR_WIDTH:0]   word_idx_p1;
  logic [ADDR_WIDTH:0]   word_cnt;
  logic [1:0]            byte_idx;
  logic [31:0]           word_buf;
  logic [7:0]            csum;
  logic                  fire;
  logic                  count_ok;
  logic                  last_word;

  assign fire        = in_valid && in_ready;
  assign count_ok    = (in_data != 8'd0) && (int'(in_data) <= DEPTH);
  assign word_idx_p1 = {1'b0, word_idx} + ONE_W;
  assign last_word   = (word_idx_p1 == word_cnt);

  // Every output is a decode of registered state, so nothing depends on in_valid/in_data.
  assign in_ready   = ready_en && (state != S_WRITE);
  assign mem_we     = (state == S_WRITE);
  assign mem_addr   = word_idx;
  assign mem_wdata  = word_buf;
  assign cpu_hold   = (state != S_DONE);
  assign load_done  = (state == S_DONE);
  assign load_error = (state == S_ERROR);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // NOTE: state_nx gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (fire) state_nx = count_ok ? S_RECV : S_ERROR;
      end
      S_RECV: begin
        if (fire && byte_idx == 2'd3) state_nx = S_WRITE;
      end
      S_WRITE: begin
        state_nx = last_word ? S_CHECK : S_RECV;
      end
      S_CHECK: begin
        if (fire) state_nx = (in_data == csum) ? S_DONE : S_ERROR;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_en     <= 1'b0;
      word_idx     <= '0;
      word_cnt     <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      csum         <= '0;
      words_loaded <= '0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (fire && count_ok) begin
            word_cnt     <= (ADDR_WIDTH+1)'(in_data);
            word_idx     <= '0;
            byte_idx     <= '0;
            csum         <= '0;
            words_loaded <= '0;
          end
        end
        S_RECV: begin
          if (fire) begin
            word_buf[{byte_idx, 3'b000} +: 8] <= in_data;
            csum                              <= csum ^ in_data;
            byte_idx                          <= byte_idx + 2'd1;
          end
        end
        S_WRITE: begin
          words_loaded <= words_loaded + ONE_W;
          // The final index is kept so the address never steps past N-1.
          if (!last_word) word_idx <= ADDR_WIDTH'(word_idx_p1);
        end
        default: ;
      endcase
    end
  end

endmodule
